fkey_unpack_stream: RTL and testbench

//  Streaming decoder for 32-bit order-preserving float keys, the inverse of the FPU compare encoding.

---
 rtl/fkey_unpack_stream_pkg.sv | 32 +++
 rtl/fkey_unpack_stream_if.sv | 30 +++
 rtl/fkey_dec.sv | 16 +
 rtl/fkey_unpack_stream.sv | 149 ++++++++++++++
 tb/tb_fkey_unpack_stream.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fkey_unpack_stream_pkg.sv
// Shared float-key definitions: field widths, the +0 key, and the key -> IEEE single decode.
package fkey_unpack_stream_pkg;

  localparam int EW = 8;
  localparam int MW = 23;
  localparam logic [31:0] KEY_ZERO = 32'h8000_0000;

  typedef struct packed {
    logic        illegal;
    logic [31:0] flt;
  } dec_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } pkt_st_e;

  // Exponent 0 is never produced by the encoder except as the +0 key, so any other such key is rejected.
  function automatic dec_t key2flt(input logic [31:0] key);
    dec_t          d;
    logic          s;
    logic [EW-1:0] e;
    logic [MW-1:0] m;
    s = ~key[31];
    e = key[31] ? key[EW+MW-1:MW] : ~key[EW+MW-1:MW];
    m = key[31] ? key[MW-1:0]     : ~key[MW-1:0];
    d.illegal = (e == '0) && (key != KEY_ZERO);
    d.flt     = d.illegal ? 32'h0000_0000 : {s, e, m};
    return d;
  endfunction

endpackage

// File: rtl/fkey_unpack_stream_if.sv
// Key-in / float-out stream bundle plus the per-packet summary sideband.
interface fkey_unpack_stream_if #(
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_key;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic             out_illegal;
  logic             out_last;
  logic             pkt_valid;
  logic [31:0]      pkt_min;
  logic [31:0]      pkt_max;
  logic [CNT_W-1:0] pkt_count;

  modport master (
    output in_valid, in_key, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_illegal, out_last,
    input  pkt_valid, pkt_min, pkt_max, pkt_count
  );

  modport slave (
    input  in_valid, in_key, in_last, out_ready,
    output in_ready, out_valid, out_data, out_illegal, out_last,
    output pkt_valid, pkt_min, pkt_max, pkt_count
  );
endinterface

// File: rtl/fkey_dec.sv
// Combinational order-preserving key to IEEE single decoder.
module fkey_dec
  import fkey_unpack_stream_pkg::*;
(
  input  logic [31:0] i_key,
  output logic [31:0] o_flt,
  output logic        o_illegal
);

  dec_t w_dec;

  assign w_dec     = key2flt(i_key);
  assign o_flt     = w_dec.flt;
  assign o_illegal = w_dec.illegal;

endmodule

// File: rtl/fkey_unpack_stream.sv
// Two-stage valid/ready float-key decoder with a per-packet unsigned min/max/count reporter.
// state   | meaning
// ST_IDLE | no packet open; next accepted word starts one
// ST_ACC  | packet open; accumulating min/max/count
module fkey_unpack_stream
  import fkey_unpack_stream_pkg::*;
#(
  parameter int CNT_W = 16
)
(
  input  logic                 clk,
  input  logic                 rstn,
  fkey_unpack_stream_if.slave  s_bus
);

  logic             w_s1_en;
  logic             w_s2_en;
  logic             w_in_fire;
  logic             r_s1_v;
  logic             r_s1_last;
  logic [31:0]      r_s1_key;
  logic             r_s2_v;
  logic             r_s2_ill;
  logic             r_s2_last;
  logic [31:0]      r_s2_data;
  logic [31:0]      w_s1_flt;
  logic             w_s1_ill;

  pkt_st_e          r_st;
  pkt_st_e          w_st_nxt;
  logic [31:0]      r_min;
  logic [31:0]      r_max;
  logic [31:0]      w_min_nxt;
  logic [31:0]      w_max_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_report;
  logic             r_pkt_v;
  logic [31:0]      r_pkt_min;
  logic [31:0]      r_pkt_max;
  logic [CNT_W-1:0] r_pkt_cnt;
  logic [31:0]      w_min_flt;
  logic [31:0]      w_max_flt;
  logic             w_min_ill;
  logic             w_max_ill;
  logic             w_unused_ill;

  // No skid buffer: ready ripples combinationally back from out_ready; held low while in reset.
  assign w_s2_en        = !r_s2_v || s_bus.out_ready;
  assign w_s1_en        = !r_s1_v || w_s2_en;
  assign s_bus.in_ready = rstn && w_s1_en;
  assign w_in_fire      = s_bus.in_valid && s_bus.in_ready;

  fkey_dec u_dec_s2  (.i_key(r_s1_key),  .o_flt(w_s1_flt),  .o_illegal(w_s1_ill));
  fkey_dec u_dec_min (.i_key(w_min_nxt), .o_flt(w_min_flt), .o_illegal(w_min_ill));
  fkey_dec u_dec_max (.i_key(w_max_nxt), .o_flt(w_max_flt), .o_illegal(w_max_ill));

  // Summary words are already forced to +0 when illegal, so the flag itself is not reported.
  assign w_unused_ill = w_min_ill ^ w_max_ill;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_s1_v    <= 1'b0;
      r_s1_key  <= '0;
      r_s1_last <= 1'b0;
    end else if (w_s1_en) begin
      r_s1_v <= s_bus.in_valid;
      if (s_bus.in_valid) begin
        r_s1_key  <= s_bus.in_key;
        r_s1_last <= s_bus.in_last;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_s2_v    <= 1'b0;
      r_s2_data <= '0;
      r_s2_ill  <= 1'b0;
      r_s2_last <= 1'b0;
    end else if (w_s2_en) begin
      r_s2_v <= r_s1_v;
      if (r_s1_v) begin
        r_s2_data <= w_s1_flt;
        r_s2_ill  <= w_s1_ill;
        r_s2_last <= r_s1_last;
      end
    end
  end

  always_comb begin
    w_st_nxt  = r_st;
    w_min_nxt = r_min;
    w_max_nxt = r_max;
    w_cnt_nxt = r_cnt;
    w_report  = 1'b0;
    if (w_in_fire) begin
      case (r_st)
        ST_IDLE: begin
          w_min_nxt = s_bus.in_key;
          w_max_nxt = s_bus.in_key;
          w_cnt_nxt = CNT_W'(1);
        end
        ST_ACC: begin
          if (s_bus.in_key < r_min) w_min_nxt = s_bus.in_key;
          if (s_bus.in_key > r_max) w_max_nxt = s_bus.in_key;
          if (!(&r_cnt)) w_cnt_nxt = r_cnt + 1'b1;
        end
        default: ;
      endcase
      w_report = s_bus.in_last;
      w_st_nxt = s_bus.in_last ? ST_IDLE : ST_ACC;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_st      <= ST_IDLE;
      r_min     <= '0;
      r_max     <= '0;
      r_cnt     <= '0;
      r_pkt_v   <= 1'b0;
      r_pkt_min <= '0;
      r_pkt_max <= '0;
      r_pkt_cnt <= '0;
    end else begin
      r_st    <= w_st_nxt;
      r_min   <= w_min_nxt;
      r_max   <= w_max_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pkt_v <= w_report;
      if (w_report) begin
        r_pkt_min <= w_min_flt;
        r_pkt_max <= w_max_flt;
        r_pkt_cnt <= w_cnt_nxt;
      end
    end
  end

  assign s_bus.out_valid   = r_s2_v;
  assign s_bus.out_data    = r_s2_data;
  assign s_bus.out_illegal = r_s2_ill;
  assign s_bus.out_last    = r_s2_last;
  assign s_bus.pkt_valid   = r_pkt_v;
  assign s_bus.pkt_min     = r_pkt_min;
  assign s_bus.pkt_max     = r_pkt_max;
  assign s_bus.pkt_count   = r_pkt_cnt;

endmodule

// File: tb/tb_fkey_unpack_stream.sv
// Directed bench for fkey_unpack_stream: decode, illegal keys, packets, backpressure, saturation, reset.
module tb_fkey_unpack_stream;

  localparam int TB_CNT_W = 4;

  logic clk;
  logic rstn;
  int   n_vec = 0;
  int   n_err = 0;

  logic [33:0]          q_out[$];
  logic [TB_CNT_W+63:0] q_pkt[$];

  fkey_unpack_stream_if #(.CNT_W(TB_CNT_W)) bus ();

  fkey_unpack_stream #(.CNT_W(TB_CNT_W)) dut (
    .clk   (clk),
    .rstn  (rstn),
    .s_bus (bus)
  );

  always #5 clk = ~clk;

  // Collect every delivered word and every packet report.
  always @(negedge clk) begin
    if (rstn) begin
      if (bus.out_valid && bus.out_ready) q_out.push_back({bus.out_illegal, bus.out_last, bus.out_data});
      if (bus.pkt_valid) q_pkt.push_back({bus.pkt_count, bus.pkt_max, bus.pkt_min});
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Entered and left at posedge+1; holds the word until it is accepted.
  task automatic send(input logic [31:0] k, input logic l);
    int guard;
    guard = 0;
    bus.in_valid = 1'b1;
    bus.in_key   = k;
    bus.in_last  = l;
    @(negedge clk);
    while (!bus.in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.in_ready) begin
      n_vec++; n_err++;
      $display("FAIL send_timeout key=%h in_ready stayed 0", k);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic test_reset();
    logic [TB_CNT_W+101:0] obs;
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    obs = {bus.in_ready, bus.out_valid, bus.out_data, bus.out_illegal, bus.out_last,
           bus.pkt_valid, bus.pkt_min, bus.pkt_max, bus.pkt_count};
    n_vec++;
    if (obs !== '0) begin n_err++; $display("FAIL reset_outputs got %h exp 0", obs); end
    rstn = 1'b1;
    @(negedge clk);
    n_vec++;
    if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_decode();
    logic [31:0] keys [3];
    logic [31:0] expd [3];
    keys = '{32'hBF80_0000, 32'h407F_FFFF, 32'h8000_0000};
    expd = '{32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000};
    bus.out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (c < 3) begin
        bus.in_valid = 1'b1; bus.in_key = keys[c]; bus.in_last = (c == 2);
      end else begin
        bus.in_valid = 1'b0; bus.in_last = 1'b0;
      end
      @(negedge clk);
      n_vec++;
      if (c >= 2 && c < 5) begin
        if (bus.out_valid !== 1'b1 || bus.out_data !== expd[c-2] || bus.out_illegal !== 1'b0) begin
          n_err++;
          $display("FAIL decode_latency cycle %0d got v=%b d=%h ill=%b exp v=1 d=%h ill=0",
                   c, bus.out_valid, bus.out_data, bus.out_illegal, expd[c-2]);
        end
      end else if (bus.out_valid !== 1'b0) begin
        n_err++; $display("FAIL decode_idle cycle %0d got out_valid=%b exp 0", c, bus.out_valid);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_illegal();
    logic [31:0] keys [6];
    logic [33:0] expd [6];
    keys = '{32'h8000_0001, 32'h7F80_0000, 32'hFF80_0000, 32'h0000_0000, 32'h7FFF_FFFF, 32'h8000_0000};
    expd = '{{2'b10, 32'h0000_0000}, {2'b10, 32'h0000_0000}, {2'b00, 32'h7F80_0000},
             {2'b00, 32'hFFFF_FFFF}, {2'b10, 32'h0000_0000}, {2'b01, 32'h0000_0000}};
    q_out.delete();
    for (int i = 0; i < 6; i++) send(keys[i], i == 5);
    wait_cycles(4);
    n_vec++;
    if (q_out.size() != 6) begin
      n_err++; $display("FAIL illegal_count got %0d words exp 6", q_out.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        n_vec++;
        if (q_out[i] !== expd[i]) begin
          n_err++; $display("FAIL illegal_word %0d got %h exp %h", i, q_out[i], expd[i]);
        end
      end
    end
  endtask

  task automatic test_packet();
    logic [TB_CNT_W+63:0] e;
    q_pkt.delete();
    send(32'hC000_0000, 1'b0);
    send(32'h3FBF_FFFF, 1'b0);
    send(32'hBF00_0000, 1'b0);
    send(32'h417F_FFFF, 1'b1);
    wait_cycles(3);
    n_vec++;
    if (q_pkt.size() != 1) begin
      n_err++; $display("FAIL packet_reports got %0d exp 1", q_pkt.size());
    end else begin
      e = q_pkt[0];
      n_vec++;
      if (e !== {4'd4, 32'h4000_0000, 32'hC040_0000}) begin
        n_err++; $display("FAIL packet_summary got cnt=%0d max=%h min=%h exp cnt=4 max=40000000 min=c0400000",
                          e[TB_CNT_W+63:64], e[63:32], e[31:0]);
      end
    end
  endtask

  task automatic test_backpressure();
    int          idx;
    int          n_acc;
    logic        acc;
    logic        held_v;
    logic [31:0] held;
    logic [33:0] exp_w;
    logic [TB_CNT_W+63:0] e;
    q_out.delete();
    q_pkt.delete();
    idx = 0; n_acc = 0; held_v = 1'b0; held = '0;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_last   = 1'b0;
    bus.in_key    = 32'hC000_0000;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      acc = bus.in_ready;
      if (bus.out_valid) begin
        if (!held_v) begin
          held = bus.out_data; held_v = 1'b1;
        end else begin
          n_vec++;
          if (bus.out_data !== held) begin
            n_err++; $display("FAIL stall_stable cycle %0d got %h exp %h", c, bus.out_data, held);
          end
        end
      end
      @(posedge clk);
      #1;
      if (acc) begin
        n_acc++; idx++;
        bus.in_key = 32'hC000_0000 + idx;
      end
    end
    n_vec++;
    if (n_acc != 2) begin n_err++; $display("FAIL stall_accepts got %0d exp 2", n_acc); end
    n_vec++;
    if (held !== 32'h4000_0000) begin n_err++; $display("FAIL stall_head got %h exp 40000000", held); end
    bus.out_ready = 1'b1;
    while (idx < 8) begin
      bus.in_last = (idx == 7);
      @(negedge clk);
      n_vec++;
      if (bus.in_ready !== 1'b1) begin
        n_err++; $display("FAIL resume_rate word %0d got in_ready=%b exp 1", idx, bus.in_ready);
      end
      @(posedge clk);
      #1;
      idx++;
      bus.in_key = 32'hC000_0000 + idx;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    wait_cycles(4);
    n_vec++;
    if (q_out.size() != 8) begin
      n_err++; $display("FAIL drain_count got %0d exp 8", q_out.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        exp_w = {1'b0, (i == 7), 32'h4000_0000 + i};
        n_vec++;
        if (q_out[i] !== exp_w) begin
          n_err++; $display("FAIL drain_order %0d got %h exp %h", i, q_out[i], exp_w);
        end
      end
    end
    n_vec++;
    if (q_pkt.size() != 1) begin
      n_err++; $display("FAIL stream_reports got %0d exp 1", q_pkt.size());
    end else begin
      e = q_pkt[0];
      n_vec++;
      if (e !== {4'd8, 32'h4000_0007, 32'h4000_0000}) begin
        n_err++; $display("FAIL stream_summary got %h exp %h", e, {4'd8, 32'h4000_0007, 32'h4000_0000});
      end
    end
  endtask

  task automatic test_saturate();
    logic [TB_CNT_W+63:0] e;
    q_pkt.delete();
    for (int i = 0; i < 20; i++) send(32'hC000_0000 + i, i == 19);
    wait_cycles(3);
    n_vec++;
    if (q_pkt.size() != 1) begin
      n_err++; $display("FAIL sat_reports got %0d exp 1", q_pkt.size());
    end else begin
      e = q_pkt[0];
      n_vec++;
      if (e !== {4'hF, 32'h4000_0013, 32'h4000_0000}) begin
        n_err++; $display("FAIL sat_summary got %h exp %h", e, {4'hF, 32'h4000_0013, 32'h4000_0000});
      end
    end
  endtask

  task automatic test_single();
    send(32'h3FBF_FFFF, 1'b1);
    @(negedge clk);
    n_vec++;
    if ({bus.pkt_valid, bus.pkt_count, bus.pkt_min, bus.pkt_max} !== {1'b1, 4'd1, 32'hC040_0000, 32'hC040_0000}) begin
      n_err++; $display("FAIL single_report got v=%b cnt=%0d min=%h max=%h exp v=1 cnt=1 min=c0400000 max=c0400000",
                        bus.pkt_valid, bus.pkt_count, bus.pkt_min, bus.pkt_max);
    end
    @(negedge clk);
    n_vec++;
    if (bus.pkt_valid !== 1'b0 || bus.pkt_count !== 4'd1) begin
      n_err++; $display("FAIL single_pulse got v=%b cnt=%0d exp v=0 cnt=1", bus.pkt_valid, bus.pkt_count);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    logic [TB_CNT_W+101:0] obs;
    logic [TB_CNT_W+63:0]  e;
    send(32'hC000_0010, 1'b0);
    send(32'hC000_0011, 1'b0);
    send(32'hC000_0012, 1'b0);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    obs = {bus.in_ready, bus.out_valid, bus.out_data, bus.out_illegal, bus.out_last,
           bus.pkt_valid, bus.pkt_min, bus.pkt_max, bus.pkt_count};
    n_vec++;
    if (obs !== '0) begin n_err++; $display("FAIL midreset_outputs got %h exp 0", obs); end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    q_out.delete();
    q_pkt.delete();
    @(posedge clk);
    #1;
    wait_cycles(2);
    n_vec++;
    if (q_pkt.size() != 0 || q_out.size() != 0) begin
      n_err++; $display("FAIL midreset_stale got pkts=%0d words=%0d exp 0 0", q_pkt.size(), q_out.size());
    end
    send(32'hBF80_0000, 1'b0);
    send(32'h407F_FFFF, 1'b1);
    wait_cycles(4);
    n_vec++;
    if (q_pkt.size() != 1) begin
      n_err++; $display("FAIL midreset_reports got %0d exp 1", q_pkt.size());
    end else begin
      e = q_pkt[0];
      n_vec++;
      if (e !== {4'd2, 32'h3F80_0000, 32'hBF80_0000}) begin
        n_err++; $display("FAIL midreset_summary got %h exp %h", e, {4'd2, 32'h3F80_0000, 32'hBF80_0000});
      end
    end
    n_vec++;
    if (q_out.size() != 2) begin n_err++; $display("FAIL midreset_words got %0d exp 2", q_out.size()); end
  endtask

  initial begin
    clk           = 1'b0;
    rstn          = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_key    = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    test_reset();
    test_decode();
    test_illegal();
    test_packet();
    test_backpressure();
    test_saturate();
    test_single();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
